// File: rtl/sys_defs.sv
// sys_defs: shared bus types, memory sizes and the scheduler's owner/grant types.
package sys_defs;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {BUS_NONE, BUS_LOAD, BUS_STORE} BUS_COMMAND;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} MEM_SIZE;
  typedef enum logic {OWNER_DCACHE, OWNER_ICACHE} OWNER_T;
  typedef struct packed {
    logic   valid;
    OWNER_T owner;
  } owner_entry_t;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_D, GRANT_I} grant_t;
endpackage

// File: rtl/mem_scheduler_if.sv
// mem_scheduler_if: cache/memory bus bundle seen by the scheduler.
interface mem_scheduler_if;
  import sys_defs::*;
  BUS_COMMAND        Dcache2mem_command;
  MEM_SIZE           Dcache2mem_size;
  logic [XLEN-1:0]   Dcache2mem_addr;
  logic [XLEN-1:0]   Dcache2mem_data;
  BUS_COMMAND        Icache2mem_command;
  logic [XLEN-1:0]   Icache2mem_addr;
  logic [3:0]        mem2cache_response;
  logic [63:0]       mem2cache_data;
  logic [3:0]        mem2cache_tag;
  BUS_COMMAND        cache2mem_command;
  MEM_SIZE           cache2mem_size;
  logic [XLEN-1:0]   cache2mem_addr;
  logic [XLEN-1:0]   cache2mem_data;
  logic [3:0]        mem2Dcache_response;
  logic [3:0]        mem2Icache_response;
  logic [63:0]       mem2Dcache_data;
  logic [63:0]       mem2Icache_data;
  logic [3:0]        mem2Dcache_tag;
  logic [3:0]        mem2Icache_tag;
  logic [4:0]        outstanding_count;
  logic              orphan_error;
  modport master (
    output Dcache2mem_command, Dcache2mem_size, Dcache2mem_addr, Dcache2mem_data,
    output Icache2mem_command, Icache2mem_addr, mem2cache_response, mem2cache_data, mem2cache_tag,
    input  cache2mem_command, cache2mem_size, cache2mem_addr, cache2mem_data,
    input  mem2Dcache_response, mem2Icache_response, mem2Dcache_data, mem2Icache_data,
    input  mem2Dcache_tag, mem2Icache_tag, outstanding_count, orphan_error
  );
  modport slave (
    input  Dcache2mem_command, Dcache2mem_size, Dcache2mem_addr, Dcache2mem_data,
    input  Icache2mem_command, Icache2mem_addr, mem2cache_response, mem2cache_data, mem2cache_tag,
    output cache2mem_command, cache2mem_size, cache2mem_addr, cache2mem_data,
    output mem2Dcache_response, mem2Icache_response, mem2Dcache_data, mem2Icache_data,
    output mem2Dcache_tag, mem2Icache_tag, outstanding_count, orphan_error
  );
endinterface

// File: rtl/mem_scheduler_tag_table.sv
// mem_tag_table: per-tag owner table with allocate/free/lookup and a running valid count.
module mem_tag_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        alloc_en_i,
  input  logic [$clog2(NUM_TAGS)-1:0] alloc_tag_i,
  input  OWNER_T                      alloc_owner_i,
  input  logic                        free_en_i,
  input  logic [$clog2(NUM_TAGS)-1:0] free_tag_i,
  input  logic [$clog2(NUM_TAGS)-1:0] lookup_tag_i,
  output logic                        lookup_valid_o,
  output OWNER_T                      lookup_owner_o,
  output logic [4:0]                  count_o
);
  owner_entry_t table_q [NUM_TAGS];
  owner_entry_t table_d [NUM_TAGS];
  logic [4:0] count_q, count_d;
  logic inc, dec;
  assign lookup_valid_o = lookup_tag_i != '0 && table_q[lookup_tag_i].valid;
  assign lookup_owner_o = table_q[lookup_tag_i].owner;
  assign count_o = count_q;
  // allocate overrides a same-tag free, so that case leaves the count unchanged
  assign inc = alloc_en_i && !table_q[alloc_tag_i].valid;
  assign dec = free_en_i && table_q[free_tag_i].valid && !(alloc_en_i && alloc_tag_i == free_tag_i);
  always_comb begin
    table_d = table_q;
    if (free_en_i) table_d[free_tag_i].valid = 1'b0;
    if (alloc_en_i) table_d[alloc_tag_i] = '{valid: 1'b1, owner: alloc_owner_i};
    count_d = count_q + 5'(inc) - 5'(dec);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      table_q <= '{default: '0};
      count_q <= '0;
    end else begin
      table_q <= table_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/mem_scheduler.sv
// mem_scheduler: Dcache-priority memory port arbiter with bounded Icache starvation
// and per-tag routing of returned load data.
module mem_scheduler
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int NUM_TAGS     = 16
) (
  input logic           clock,
  input logic           reset,
  mem_scheduler_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
  logic orphan_q, orphan_d;
  logic d_req, i_req, accepted, alloc_en, hit;
  grant_t grant;
  BUS_COMMAND cmd;
  OWNER_T owner;
  assign d_req = bus.Dcache2mem_command != BUS_NONE;
  assign i_req = bus.Icache2mem_command != BUS_NONE;
  assign accepted = bus.mem2cache_response != 4'd0;
  always_comb begin
    grant = (i_req && starve_q == SW'(STARVE_LIMIT)) ? GRANT_I : d_req ? GRANT_D : i_req ? GRANT_I : GRANT_NONE;
    cmd = grant == GRANT_D ? bus.Dcache2mem_command : grant == GRANT_I ? bus.Icache2mem_command : BUS_NONE;
    starve_d = (!i_req || (grant == GRANT_I && accepted)) ? '0 :
               starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1);
    orphan_d = orphan_q | (bus.mem2cache_tag != 4'd0 && !hit);
  end
  assign bus.cache2mem_command   = cmd;
  assign bus.cache2mem_size      = grant == GRANT_D ? bus.Dcache2mem_size : DOUBLE;
  assign bus.cache2mem_addr      = grant == GRANT_D ? bus.Dcache2mem_addr : grant == GRANT_I ? bus.Icache2mem_addr : '0;
  assign bus.cache2mem_data      = grant == GRANT_D ? bus.Dcache2mem_data : '0;
  assign bus.mem2Dcache_response = grant == GRANT_D ? bus.mem2cache_response : 4'd0;
  assign bus.mem2Icache_response = grant == GRANT_I ? bus.mem2cache_response : 4'd0;
  assign bus.mem2Dcache_data     = bus.mem2cache_data;
  assign bus.mem2Icache_data     = bus.mem2cache_data;
  assign bus.mem2Dcache_tag      = (hit && owner == OWNER_DCACHE) ? bus.mem2cache_tag : 4'd0;
  assign bus.mem2Icache_tag      = (hit && owner == OWNER_ICACHE) ? bus.mem2cache_tag : 4'd0;
  assign bus.orphan_error        = orphan_q;
  assign alloc_en = cmd == BUS_LOAD && accepted;
  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en_i    (alloc_en),
    .alloc_tag_i   (bus.mem2cache_response),
    .alloc_owner_i (grant == GRANT_I ? OWNER_ICACHE : OWNER_DCACHE),
    .free_en_i     (hit),
    .free_tag_i    (bus.mem2cache_tag),
    .lookup_tag_i  (bus.mem2cache_tag),
    .lookup_valid_o(hit),
    .lookup_owner_o(owner),
    .count_o       (bus.outstanding_count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
      orphan_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      orphan_q <= orphan_d;
    end
  end
endmodule

// File: tb/tb_mem_scheduler.sv
// tb_mem_scheduler: directed vector table plus a starvation sequence for mem_scheduler.
module tb_mem_scheduler;
  import sys_defs::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mem_scheduler_if bus();
  mem_scheduler #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (.clock(clk), .reset(rst), .bus(bus));
  typedef struct {
    logic rst;
    BUS_COMMAND d_cmd; MEM_SIZE d_size; logic [31:0] d_addr; logic [31:0] d_data;
    BUS_COMMAND i_cmd; logic [31:0] i_addr;
    logic [3:0] resp; logic [3:0] rtag;
    BUS_COMMAND e_cmd; MEM_SIZE e_size; logic [31:0] e_addr; logic [31:0] e_data;
    logic [3:0] e_dresp; logic [3:0] e_iresp; logic [3:0] e_dtag; logic [3:0] e_itag;
    logic [4:0] e_cnt; logic e_orph;
  } vec_t;
  vec_t v [17];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic r, input BUS_COMMAND dc, input MEM_SIZE ds, input logic [31:0] da,
                       input logic [31:0] dd, input BUS_COMMAND ic, input logic [31:0] ia,
                       input logic [3:0] rs, input logic [3:0] rt, input logic [63:0] rd);
    rst = r;
    bus.Dcache2mem_command = dc; bus.Dcache2mem_size = ds;
    bus.Dcache2mem_addr = da; bus.Dcache2mem_data = dd;
    bus.Icache2mem_command = ic; bus.Icache2mem_addr = ia;
    bus.mem2cache_response = rs; bus.mem2cache_tag = rt; bus.mem2cache_data = rd;
  endtask
  initial begin
    v[0]  = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd0,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0};
    v[1]  = '{0, BUS_LOAD, WORD, 32'h100, 32'h55, BUS_LOAD, 32'h200, 4'd3, 4'd0,
              BUS_LOAD, WORD, 32'h100, 32'h55, 4'd3, 4'd0, 4'd0, 4'd0, 5'd1, 1'b0};
    v[2]  = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd3,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd3, 4'd0, 5'd0, 1'b0};
    v[3]  = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_LOAD, 32'h300, 4'd5, 4'd0,
              BUS_LOAD, DOUBLE, 32'h300, 32'h0, 4'd0, 4'd5, 4'd0, 4'd0, 5'd1, 1'b0};
    v[4]  = '{0, BUS_LOAD, DOUBLE, 32'h400, 32'h44, BUS_NONE, 32'h0, 4'd6, 4'd0,
              BUS_LOAD, DOUBLE, 32'h400, 32'h44, 4'd6, 4'd0, 4'd0, 4'd0, 5'd2, 1'b0};
    v[5]  = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_LOAD, 32'h500, 4'd0, 4'd6,
              BUS_LOAD, DOUBLE, 32'h500, 32'h0, 4'd0, 4'd0, 4'd6, 4'd0, 5'd1, 1'b0};
    v[6]  = '{0, BUS_LOAD, WORD, 32'h600, 32'h66, BUS_NONE, 32'h0, 4'd0, 4'd5,
              BUS_LOAD, WORD, 32'h600, 32'h66, 4'd0, 4'd0, 4'd0, 4'd5, 5'd0, 1'b0};
    v[7]  = '{0, BUS_STORE, WORD, 32'h700, 32'h77, BUS_NONE, 32'h0, 4'd2, 4'd0,
              BUS_STORE, WORD, 32'h700, 32'h77, 4'd2, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0};
    v[8]  = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd2,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b1};
    v[9]  = '{1, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd0,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0};
    v[10] = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_LOAD, 32'h800, 4'd7, 4'd0,
              BUS_LOAD, DOUBLE, 32'h800, 32'h0, 4'd0, 4'd7, 4'd0, 4'd0, 5'd1, 1'b0};
    v[11] = '{1, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd0,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0};
    v[12] = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd7,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b1};
    v[13] = '{1, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd0,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0};
    v[14] = '{0, BUS_LOAD, DOUBLE, 32'h900, 32'h99, BUS_NONE, 32'h0, 4'd4, 4'd0,
              BUS_LOAD, DOUBLE, 32'h900, 32'h99, 4'd4, 4'd0, 4'd0, 4'd0, 5'd1, 1'b0};
    v[15] = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_LOAD, 32'hA00, 4'd4, 4'd4,
              BUS_LOAD, DOUBLE, 32'hA00, 32'h0, 4'd0, 4'd4, 4'd4, 4'd0, 5'd1, 1'b0};
    v[16] = '{0, BUS_NONE, DOUBLE, 32'h0, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd4,
              BUS_NONE, DOUBLE, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 4'd4, 5'd0, 1'b0};
    drive(1, BUS_NONE, DOUBLE, 0, 0, BUS_NONE, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 64'(bus.outstanding_count), 64'd0);
    check("reset_orphan", 64'(bus.orphan_error), 64'd0);
    for (int i = 0; i < 17; i++) begin
      logic [63:0] rd;
      @(negedge clk);
      rd = 64'hC0DE_0000_0000_0000 | 64'(i);
      drive(v[i].rst, v[i].d_cmd, v[i].d_size, v[i].d_addr, v[i].d_data, v[i].i_cmd, v[i].i_addr,
            v[i].resp, v[i].rtag, rd);
      #1;
      check($sformatf("v%0d_cmd", i), 64'(bus.cache2mem_command), 64'(v[i].e_cmd));
      check($sformatf("v%0d_size", i), 64'(bus.cache2mem_size), 64'(v[i].e_size));
      check($sformatf("v%0d_addr", i), 64'(bus.cache2mem_addr), 64'(v[i].e_addr));
      check($sformatf("v%0d_data", i), 64'(bus.cache2mem_data), 64'(v[i].e_data));
      check($sformatf("v%0d_dresp", i), 64'(bus.mem2Dcache_response), 64'(v[i].e_dresp));
      check($sformatf("v%0d_iresp", i), 64'(bus.mem2Icache_response), 64'(v[i].e_iresp));
      check($sformatf("v%0d_dtag", i), 64'(bus.mem2Dcache_tag), 64'(v[i].e_dtag));
      check($sformatf("v%0d_itag", i), 64'(bus.mem2Icache_tag), 64'(v[i].e_itag));
      check($sformatf("v%0d_ddata", i), bus.mem2Dcache_data, rd);
      check($sformatf("v%0d_idata", i), bus.mem2Icache_data, rd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_count", i), 64'(bus.outstanding_count), 64'(v[i].e_cnt));
      check($sformatf("v%0d_orphan", i), 64'(bus.orphan_error), 64'(v[i].e_orph));
    end
    @(negedge clk);
    drive(1, BUS_NONE, DOUBLE, 0, 0, BUS_NONE, 0, 0, 0, 0);
    @(negedge clk);
    for (int c = 0; c < 15; c++) begin
      logic ig;
      ig = (c % 5) == 4;
      drive(0, BUS_LOAD, DOUBLE, 32'h1000, 32'h0, BUS_LOAD, 32'h2000, 4'(c + 1), 4'd0, 64'd0);
      #1;
      check($sformatf("starve%0d_addr", c), 64'(bus.cache2mem_addr), ig ? 64'h2000 : 64'h1000);
      check($sformatf("starve%0d_iresp", c), 64'(bus.mem2Icache_response), ig ? 64'(c + 1) : 64'd0);
      @(negedge clk);
    end
    check("starve_count", 64'(bus.outstanding_count), 64'd15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_scheduler.md
# mem_scheduler

Shares the single main-memory port between the Dcache and Icache, with Dcache priority and bounded Icache starvation. Returned load data is routed by a per-tag owner table, so a response reaches the cache that issued the request even when the other cache is using the bus at return time. Sits between both caches and `mem`, and replaces the current purely combinational arbitration.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive denied Icache cycles before the Icache is forced to win.
- `NUM_TAGS`, default 16: memory tag space; tag 0 means "none".

Ports (clock and reset first):
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `Dcache2mem_command` in BUS_COMMAND: Dcache request.
- `Dcache2mem_size` in MEM_SIZE: Dcache access size.
- `Dcache2mem_addr` in `XLEN`: Dcache address.
- `Dcache2mem_data` in `XLEN`: Dcache store data.
- `Icache2mem_command` in BUS_COMMAND: Icache request; loads only, size is always DOUBLE.
- `Icache2mem_addr` in `XLEN`: Icache address.
- `mem2cache_response` in 4: acceptance tag from memory; 0 means rejected.
- `mem2cache_data` in 64: returned data.
- `mem2cache_tag` in 4: completion tag; 0 means no data this cycle.
- `cache2mem_command` out BUS_COMMAND: command to memory.
- `cache2mem_size` out MEM_SIZE: size to memory.
- `cache2mem_addr` out `XLEN`: address to memory.
- `cache2mem_data` out `XLEN`: store data to memory.
- `mem2Dcache_response` out 4: acceptance tag to Dcache; 0 unless Dcache is granted.
- `mem2Icache_response` out 4: acceptance tag to Icache; 0 unless Icache is granted.
- `mem2Dcache_data` out 64: data to Dcache.
- `mem2Icache_data` out 64: data to Icache.
- `mem2Dcache_tag` out 4: completion tag to Dcache; 0 unless the tag is owned by Dcache.
- `mem2Icache_tag` out 4: completion tag to Icache; 0 unless the tag is owned by Icache.
- `outstanding_count` out 5: number of valid owner-table entries.
- `orphan_error` out 1: sticky; set when a completion tag is not in the table.

## Operation
- **Grant (combinational):**
  - Icache wins if `starve_cnt == STARVE_LIMIT` and it is requesting.
  - Otherwise Dcache wins if its command is not BUS_NONE.
  - Otherwise Icache wins if requesting.
  - Otherwise no grant.
- **Memory outputs follow the winner.**
  - Icache winner: size DOUBLE, data 0.
  - No grant: command BUS_NONE, size DOUBLE, address 0, data 0.
- **Acceptance routing:** `mem2cache_response` is forwarded only to the granted cache; the other cache sees 0.
- **Owner table:**
  - `NUM_TAGS` entries, each {valid, owner}.
  - A BUS_LOAD accepted with tag t sets entry t valid, with owner = winner.
  - BUS_STORE never allocates.
- **Completion:**
  - `mem2cache_tag` = t != 0 and entry t valid: drive the owning cache's `*_tag` = t; clear entry t at the clock edge.
  - `mem2cache_data` goes to both data outputs unconditionally; only the tag qualifies it.
  - Entry t invalid: both tags 0 and `orphan_error` sets.
- **Simultaneous free and allocate of the same tag:** the allocate wins, so the entry stays valid with the new owner.
- **Starvation counter `starve_cnt`:**
  - Increments, saturating at `STARVE_LIMIT`, when the Icache requests and is not granted or is rejected.
  - Clears when the Icache is granted and accepted, or when the Icache is idle.
- **`outstanding_count`:** registered popcount of table valids, updated with +1/−1/0 per cycle.

## Timing
- **Reset values:** table all invalid, `starve_cnt` 0, `outstanding_count` 0, `orphan_error` 0. Combinational outputs take the no-grant/zero values while both requests are BUS_NONE.
- **Reset mid-operation:** the table is cleared and later completions for pre-reset tags raise `orphan_error`.
- **Zero-cycle paths:** grant, forwarding to memory and response routing are combinational, so caches see acceptance in their request cycle.
- **Completion lookup:** uses the registered table, so a tag allocated in cycle N is routable from N+1. Memory latency is at least 1, so this is sufficient.
- **Starvation bound:** the Icache is denied at most `STARVE_LIMIT` consecutive requesting cycles, provided memory accepts.

## Structure
- BUS_COMMAND, MEM_SIZE and `XLEN` stay in the shared `sys_defs` package.
- Add an OWNER_T enum (OWNER_DCACHE, OWNER_ICACHE) and an owner-entry struct there.
- One sub-module, `mem_tag_table`, holds the owner table with its allocate/free/lookup ports and the outstanding counter.
- Grant and starvation logic stay in `mem_scheduler`.

## Test plan
- **Dcache priority:** both request loads, response=3 → Dcache `response` 3, Icache `response` 0, and entry 3 owner is Dcache. Later `mem2cache_tag`=3 → only `mem2Dcache_tag`=3, and `outstanding_count` returns to 0.
- **Out-of-order return during foreign traffic:** Icache load accepted with tag 5, then Dcache load accepted with tag 6. Tag 6 returns while the Icache is driving a new request → `mem2Dcache_tag`=6. Tag 5 returns while the Dcache is driving a new request → `mem2Icache_tag`=5.
- **Starvation:** Dcache requests continuously, Icache continuously, memory always accepts, `STARVE_LIMIT`=4 → Icache granted on every 5th cycle.
- **Store does not allocate:** Dcache BUS_STORE accepted with tag 2 → `outstanding_count` stays 0. A later `mem2cache_tag`=2 → `orphan_error` becomes 1 and both tags are 0.
- **Reset mid-flight:** Icache load outstanding on tag 7, assert `reset` one cycle → count 0. Tag 7 later returns → `orphan_error` set, no tag forwarded.
- **Free/allocate collision:** tag 4 (Dcache) completes in the same cycle an Icache load is accepted with tag 4 → entry 4 valid with Icache owner, count unchanged.
